// File: rtl/data_mem_ctrl_if.sv
// Core, loader and RAM signal bundle for data_mem_ctrl; slave is the controller side.
interface data_mem_ctrl_if;
  logic        c_req;
  logic        c_we;
  logic [2:0]  c_funct3;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [31:0] c_rdata;
  logic        c_ready;
  logic        c_err;

  logic        l_req;
  logic        l_we;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic [31:0] l_rdata;
  logic        l_ready;
  logic        l_err;

  logic        ram_we;
  logic        ram_re;
  logic [31:0] ram_a;
  logic [31:0] ram_wd;
  logic [31:0] ram_rd;

  modport slave (
    input  c_req, c_we, c_funct3, c_addr, c_wdata,
    output c_rdata, c_ready, c_err,
    input  l_req, l_we, l_addr, l_wdata,
    output l_rdata, l_ready, l_err,
    output ram_we, ram_re, ram_a, ram_wd,
    input  ram_rd
  );

  modport master (
    output c_req, c_we, c_funct3, c_addr, c_wdata,
    input  c_rdata, c_ready, c_err,
    output l_req, l_we, l_addr, l_wdata,
    input  l_rdata, l_ready, l_err,
    input  ram_we, ram_re, ram_a, ram_wd,
    output ram_rd
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Two-port (core/loader) data RAM controller: loads and word stores complete in 2 cycles, sub-word stores in 3 (RMW), errors in 1.
// Requesters hold their request until the one-cycle ready pulse; one transaction in flight, round-robin grant.
module data_mem_ctrl #(
  parameter int MEM_BYTES = 4096
) (
  input  logic            clk,
  input  logic            rst,
  data_mem_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, ACC, RD, WR, RESP} state_t;

  localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;  // 1 = loader was granted last
  logic        port_core_q, port_core_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] word_q, word_d;
  logic [31:0] c_rdata_q, c_rdata_d;
  logic [31:0] l_rdata_q, l_rdata_d;

  logic        grant_core, grant_ldr;
  logic [31:0] req_addr;
  logic [2:0]  req_f3;
  logic        req_err;
  logic [31:0] lane;
  logic [31:0] load_val;
  logic [31:0] merged;

  always_comb begin
    grant_core = bus.c_req && (!bus.l_req || last_grant_q);
    grant_ldr  = bus.l_req && !grant_core;
    req_addr   = grant_core ? bus.c_addr : bus.l_addr;
    req_f3     = grant_core ? bus.c_funct3 : 3'd2;
    req_err    = (req_addr > MAX_ADDR);
    case (req_f3)
      3'd1, 3'd5:       req_err = req_err | req_addr[0];
      3'd2:             req_err = req_err | (|req_addr[1:0]);
      3'd3, 3'd6, 3'd7: req_err = 1'b1;
      default:          req_err = req_err;
    endcase
  end

  always_comb begin
    lane = bus.ram_rd >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'd0:    load_val = {{24{lane[7]}}, lane[7:0]};
      3'd1:    load_val = {{16{lane[15]}}, lane[15:0]};
      3'd4:    load_val = {24'd0, lane[7:0]};
      3'd5:    load_val = {16'd0, lane[15:0]};
      default: load_val = bus.ram_rd;
    endcase
  end

  // f3 bit 0 distinguishes half (sh) from byte (sb) on the RMW path
  always_comb begin
    merged = word_q;
    if (f3_q[0]) begin
      if (addr_q[1]) merged[31:16] = wdata_q[15:0];
      else           merged[15:0]  = wdata_q[15:0];
    end else begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    port_core_d  = port_core_q;
    we_d         = we_q;
    f3_d         = f3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    word_d       = word_q;
    c_rdata_d    = c_rdata_q;
    l_rdata_d    = l_rdata_q;

    case (state_q)
      IDLE: begin
        if (grant_core || grant_ldr) begin
          port_core_d  = grant_core;
          last_grant_d = grant_ldr;
          we_d         = grant_core ? bus.c_we : bus.l_we;
          wdata_d      = grant_core ? bus.c_wdata : bus.l_wdata;
          f3_d         = req_f3;
          addr_d       = req_addr;
          err_d        = req_err;
          if (req_err) begin
            state_d = RESP;
            if (grant_core) c_rdata_d = 32'd0;
            else            l_rdata_d = 32'd0;
          end else if (grant_core && bus.c_we && req_f3 != 3'd2) begin
            state_d = RD;
          end else begin
            state_d = ACC;
          end
        end
      end
      ACC: begin
        if (!we_q) begin
          if (port_core_q) c_rdata_d = load_val;
          else             l_rdata_d = bus.ram_rd;
        end
        state_d = RESP;
      end
      RD: begin
        word_d  = bus.ram_rd;
        state_d = WR;
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Enables are gated by rst so a reset landing on ACC/WR never commits a write
  always_comb begin
    bus.ram_re  = !rst && ((state_q == ACC && !we_q) || state_q == RD);
    bus.ram_we  = !rst && ((state_q == ACC && we_q) || state_q == WR);
    bus.ram_a   = {addr_q[31:2], 2'b00};
    bus.ram_wd  = 32'd0;
    if (state_q == ACC && we_q) bus.ram_wd = wdata_q;
    else if (state_q == WR)     bus.ram_wd = merged;
    bus.c_ready = (state_q == RESP) && port_core_q;
    bus.l_ready = (state_q == RESP) && !port_core_q;
    bus.c_err   = bus.c_ready && err_q;
    bus.l_err   = bus.l_ready && err_q;
    bus.c_rdata = c_rdata_q;
    bus.l_rdata = l_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      port_core_q  <= 1'b0;
      we_q         <= 1'b0;
      f3_q         <= 3'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      err_q        <= 1'b0;
      word_q       <= 32'd0;
      c_rdata_q    <= 32'd0;
      l_rdata_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      port_core_q  <= port_core_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      word_q       <= word_d;
      c_rdata_q    <= c_rdata_d;
      l_rdata_q    <= l_rdata_d;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a behavioural word RAM and per-cycle enable/ready tracking.
module tb_data_mem_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  data_mem_ctrl_if bus ();

  data_mem_ctrl #(.MEM_BYTES(4096)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [0:1023];

  assign bus.ram_rd = bus.ram_re ? mem[bus.ram_a[11:2]] : 32'd0;

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_a[11:2]] <= bus.ram_wd;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500us");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge in IDLE; mask bit k-1 marks cycle N+k after grant edge N.
  task automatic do_op(input bit core, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata, input string tag,
                       input int exp_lat, input logic exp_err, input bit chk_rd,
                       input logic [31:0] exp_rd, input logic [7:0] exp_re,
                       input logic [7:0] exp_we, input logic [31:0] exp_wd);
    int          lat;
    logic [7:0]  re_m, we_m;
    logic [31:0] wd_s, a_s, rd_s;
    logic        err_s, other, both;
    lat = 0; re_m = 0; we_m = 0; wd_s = 0; a_s = 0; rd_s = 0; err_s = 0; other = 0; both = 0;
    if (core) begin
      bus.c_req = 1'b1; bus.c_we = we; bus.c_funct3 = f3; bus.c_addr = addr; bus.c_wdata = wdata;
    end else begin
      bus.l_req = 1'b1; bus.l_we = we; bus.l_addr = addr; bus.l_wdata = wdata;
    end
    @(posedge clk);
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      if (bus.ram_re && bus.ram_we) both = 1'b1;
      if (bus.ram_re) begin re_m[k-1] = 1'b1; a_s = bus.ram_a; end
      if (bus.ram_we) begin we_m[k-1] = 1'b1; a_s = bus.ram_a; wd_s = bus.ram_wd; end
      if (core ? bus.l_ready : bus.c_ready) other = 1'b1;
      if (core ? bus.c_ready : bus.l_ready) begin
        lat   = k;
        err_s = core ? bus.c_err : bus.l_err;
        rd_s  = core ? bus.c_rdata : bus.l_rdata;
        // dropping here, mid-RESP, stops the controller from seeing a new request in IDLE
        bus.c_req = 1'b0;
        bus.l_req = 1'b0;
      end
    end
    bus.c_req = 1'b0;
    bus.l_req = 1'b0;
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_err"}, {31'd0, err_s}, {31'd0, exp_err});
    check({tag, "_re"}, {24'd0, re_m}, {24'd0, exp_re});
    check({tag, "_we"}, {24'd0, we_m}, {24'd0, exp_we});
    check({tag, "_other_rdy"}, {31'd0, other}, 32'd0);
    check({tag, "_re_we_overlap"}, {31'd0, both}, 32'd0);
    if (chk_rd) check({tag, "_rdata"}, rd_s, exp_rd);
    if (exp_we != 8'd0) check({tag, "_wd"}, wd_s, exp_wd);
    if ((exp_re | exp_we) != 8'd0) check({tag, "_a"}, a_s, addr & 32'hFFFF_FFFC);
    @(posedge clk);
    @(negedge clk);
  endtask

  int   ev [0:3];
  int   n_ev;
  logic dual_rdy;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.c_req = 0; bus.c_we = 0; bus.c_funct3 = 0; bus.c_addr = 0; bus.c_wdata = 0;
    bus.l_req = 0; bus.l_we = 0; bus.l_addr = 0; bus.l_wdata = 0;
    repeat (3) @(negedge clk);
    check("rst_c_ready", {31'd0, bus.c_ready}, 32'd0);
    check("rst_l_ready", {31'd0, bus.l_ready}, 32'd0);
    check("rst_c_err", {31'd0, bus.c_err}, 32'd0);
    check("rst_l_err", {31'd0, bus.l_err}, 32'd0);
    check("rst_c_rdata", bus.c_rdata, 32'd0);
    check("rst_l_rdata", bus.l_rdata, 32'd0);
    check("rst_ram_en", {30'd0, bus.ram_we, bus.ram_re}, 32'd0);
    check("rst_ram_a", bus.ram_a, 32'd0);
    check("rst_ram_wd", bus.ram_wd, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // core word store/load and sign/zero extension
    do_op(1, 1, 3'd2, 32'h10, 32'h80FF7F01, "sw10", 2, 0, 0, 0, 8'h00, 8'h01, 32'h80FF7F01);
    check("sw10_mem", mem[4], 32'h80FF7F01);
    do_op(1, 0, 3'd2, 32'h10, 0, "lw10",  2, 0, 1, 32'h80FF7F01, 8'h01, 8'h00, 0);
    do_op(1, 0, 3'd0, 32'h11, 0, "lb11",  2, 0, 1, 32'h0000007F, 8'h01, 8'h00, 0);
    do_op(1, 0, 3'd0, 32'h12, 0, "lb12",  2, 0, 1, 32'hFFFFFFFF, 8'h01, 8'h00, 0);
    do_op(1, 0, 3'd5, 32'h12, 0, "lhu12", 2, 0, 1, 32'h000080FF, 8'h01, 8'h00, 0);
    do_op(1, 0, 3'd1, 32'h12, 0, "lh12",  2, 0, 1, 32'hFFFF80FF, 8'h01, 8'h00, 0);
    do_op(1, 0, 3'd4, 32'h13, 0, "lbu13", 2, 0, 1, 32'h00000080, 8'h01, 8'h00, 0);
    do_op(1, 0, 3'd0, 32'h13, 0, "lb13",  2, 0, 1, 32'hFFFFFF80, 8'h01, 8'h00, 0);
    do_op(1, 0, 3'd5, 32'h10, 0, "lhu10", 2, 0, 1, 32'h00007F01, 8'h01, 8'h00, 0);

    // sub-word stores through read-modify-write
    do_op(1, 1, 3'd0, 32'h13, 32'h000000AA, "sb13", 3, 0, 0, 0, 8'h01, 8'h02, 32'hAAFF7F01);
    do_op(1, 0, 3'd2, 32'h10, 0, "lw10b", 2, 0, 1, 32'hAAFF7F01, 8'h01, 8'h00, 0);
    do_op(1, 1, 3'd1, 32'h12, 32'hFFFF1234, "sh12", 3, 0, 0, 0, 8'h01, 8'h02, 32'h12347F01);
    do_op(1, 0, 3'd5, 32'h12, 0, "lhu12b", 2, 0, 1, 32'h00001234, 8'h01, 8'h00, 0);
    do_op(1, 0, 3'd0, 32'h10, 0, "lb10",   2, 0, 1, 32'h00000001, 8'h01, 8'h00, 0);

    // error responses: one cycle, no RAM enables, rdata cleared
    do_op(1, 0, 3'd2, 32'h12,   0, "err_lw12",  1, 1, 1, 32'd0, 8'h00, 8'h00, 0);
    do_op(1, 1, 3'd1, 32'h11,   0, "err_sh11",  1, 1, 1, 32'd0, 8'h00, 8'h00, 0);
    do_op(1, 0, 3'd2, 32'h1000, 0, "err_lwtop", 1, 1, 1, 32'd0, 8'h00, 8'h00, 0);
    do_op(1, 0, 3'd3, 32'h10,   0, "err_f3_3",  1, 1, 1, 32'd0, 8'h00, 8'h00, 0);
    do_op(1, 0, 3'd5, 32'h13,   0, "err_lhu13", 1, 1, 1, 32'd0, 8'h00, 8'h00, 0);
    do_op(1, 0, 3'd0, 32'hFFF,  0, "err_lbFFF", 1, 1, 1, 32'd0, 8'h00, 8'h00, 0);
    check("err_mem_intact", mem[4], 32'h12347F01);

    // highest legal word
    do_op(1, 1, 3'd2, 32'hFFC, 32'h5A5AA5A5, "swFFC", 2, 0, 0, 0, 8'h00, 8'h01, 32'h5A5AA5A5);
    do_op(1, 0, 3'd2, 32'hFFC, 0, "lwFFC", 2, 0, 1, 32'h5A5AA5A5, 8'h01, 8'h00, 0);

    // loader port
    do_op(0, 1, 3'd0, 32'h20, 32'hDEADBEEF, "ld_sw20", 2, 0, 0, 0, 8'h00, 8'h01, 32'hDEADBEEF);
    do_op(0, 0, 3'd0, 32'h20, 0, "ld_lw20", 2, 0, 1, 32'hDEADBEEF, 8'h01, 8'h00, 0);
    do_op(0, 0, 3'd0, 32'h22, 0, "ld_err22", 1, 1, 1, 32'd0, 8'h00, 8'h00, 0);
    check("c_rdata_held", bus.c_rdata, 32'h5A5AA5A5);

    // reset during the WR cycle of an sb
    bus.c_req = 1; bus.c_we = 1; bus.c_funct3 = 3'd0; bus.c_addr = 32'h10; bus.c_wdata = 32'h55;
    @(posedge clk);
    @(negedge clk);
    check("abort_rd_re", {31'd0, bus.ram_re}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.c_req = 1'b0;
    #1;
    check("abort_wr_we", {31'd0, bus.ram_we}, 32'd0);
    dual_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.c_ready || bus.ram_we) dual_rdy = 1'b1;
    end
    check("abort_no_ready", {31'd0, dual_rdy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_mem", mem[4], 32'h12347F01);
    do_op(1, 0, 3'd2, 32'h10, 0, "abort_lw", 2, 0, 1, 32'h12347F01, 8'h01, 8'h00, 0);

    // both ports held from reset: grants alternate core, loader, core
    rst = 1'b1;
    bus.c_we = 0; bus.c_funct3 = 3'd2; bus.c_addr = 32'h10;
    bus.l_we = 0; bus.l_addr = 32'h20;
    bus.c_req = 1; bus.l_req = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_ev = 0;
    dual_rdy = 1'b0;
    for (int k = 0; k < 30 && n_ev < 3; k++) begin
      @(negedge clk);
      if (bus.c_ready && bus.l_ready) dual_rdy = 1'b1;
      if (bus.c_ready) begin ev[n_ev] = 1; n_ev++; end
      else if (bus.l_ready) begin ev[n_ev] = 2; n_ev++; end
    end
    bus.c_req = 0;
    bus.l_req = 0;
    check("arb_count", 32'(n_ev), 32'd3);
    check("arb_first", 32'(ev[0]), 32'd1);
    check("arb_second", 32'(ev[1]), 32'd2);
    check("arb_third", 32'(ev[2]), 32'd1);
    check("arb_dual_ready", {31'd0, dual_rdy}, 32'd0);
    check("arb_c_rdata", bus.c_rdata, 32'h12347F01);
    check("arb_l_rdata", bus.l_rdata, 32'hDEADBEEF);
    @(posedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
